// File: rtl/ramsr_pkg.sv
// Shared types and helpers for the multi-channel RAM delay line.
// Holds state encoding, delay clamping and modulo pointer subtraction.
package ramsr_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clamp_delay(input int value, input int wdepth);
        if (value < 1) begin
            return 1;
        end
        if (value > wdepth) begin
            return wdepth;
        end
        return value;
    endfunction

    // Explicit wrap so that non-power-of-2 depths are handled correctly
    function automatic int wrap_sub(input int ptr, input int d, input int wdepth);
        if (ptr >= d) begin
            return ptr - d;
        end
        return ptr + wdepth - d;
    endfunction

endpackage

// File: rtl/ramsr_dpram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// The caller registers rdata on the write edge, giving read-first data.
module ramsr_dpram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 10,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/ram_delay_line_mc.sv
// Multi-channel programmable RAM delay line with fill tracking.
// RAMSR_QMASK_EN: zero Q in the output register while q_valid is low.
module ram_delay_line_mc
    import ramsr_pkg::*;
#(
    parameter int DSIZE         = 1,
    parameter int NCH           = 1,
    parameter int WDEPTH        = 10,
    parameter int ASIZE         = $clog2(WDEPTH),
    parameter int DLY_W         = $clog2(WDEPTH + 1),
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 ce,
    input  logic [NCH*DSIZE-1:0] Din,
    input  logic [DLY_W-1:0]     delay_in,
    input  logic                 delay_ld,
    output logic [NCH*DSIZE-1:0] Q,
    output logic                 q_valid,
    output logic [DLY_W-1:0]     delay_cur
);

    localparam int W = NCH * DSIZE;

    logic [ASIZE-1:0] r_wr_ptr;
    logic [W-1:0]     r_q;
    logic             r_valid;
    logic [DLY_W-1:0] r_delay;
    logic [DLY_W-1:0] r_fill;
    state_t           r_state;

    logic [ASIZE-1:0] w_rd_addr;
    logic [ASIZE-1:0] w_wr_nxt;
    logic [W-1:0]     w_rdata;
    logic             w_we;
    logic [DLY_W-1:0] w_fill_inc;
    logic [DLY_W-1:0] w_ld_delay;
    state_t           w_state_nxt;
    logic [DLY_W-1:0] w_fill_nxt;
    logic             w_valid_nxt;
    logic [DLY_W-1:0] w_delay_nxt;

    assign w_rd_addr = ASIZE'(wrap_sub(int'(r_wr_ptr), int'(r_delay), WDEPTH));
    assign w_wr_nxt = (r_wr_ptr == ASIZE'(WDEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_we = ce && !Reset;
    assign w_ld_delay = DLY_W'(clamp_delay(int'(delay_in), WDEPTH));
    assign w_fill_inc = (r_fill == DLY_W'(WDEPTH)) ? r_fill : r_fill + 1'b1;

    ramsr_dpram #(
        .WIDTH (W),
        .DEPTH (WDEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (Din),
        .raddr (w_rd_addr),
        .rdata (w_rdata)
    );

    // A load wins over the fill step of the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_valid_nxt = r_valid;
        w_delay_nxt = r_delay;
        if (delay_ld) begin
            w_delay_nxt = w_ld_delay;
            w_fill_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_FILL;
        end else if (ce) begin
            unique case (r_state)
                ST_FILL: begin
                    w_fill_nxt = w_fill_inc;
                    if (w_fill_inc == r_delay) begin
                        w_state_nxt = ST_RUN;
                        w_valid_nxt = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_valid_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_FILL;
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_delay <= DLY_W'(DEFAULT_DELAY);
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_valid <= w_valid_nxt;
            r_delay <= w_delay_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_q      <= '0;
        end else begin
            if (ce) begin
                r_wr_ptr <= w_wr_nxt;
            end
`ifdef RAMSR_QMASK_EN
            if (ce || delay_ld) begin
                r_q <= w_valid_nxt ? w_rdata : '0;
            end
`else
            if (ce) begin
                r_q <= w_rdata;
            end
`endif
        end
    end

    assign Q         = r_q;
    assign q_valid   = r_valid;
    assign delay_cur = r_delay;

endmodule

// File: tb/tb_ram_delay_line_mc.sv
// Self-checking bench for ram_delay_line_mc (2 x 8-bit lanes, depth 10).
// A sample-stream model checks every cycle; directed literals pin it down.
module tb_ram_delay_line_mc;

    localparam int DSIZE = 8;
    localparam int NCH   = 2;
    localparam int WD    = 10;
    localparam int DLY_W = $clog2(WD + 1);

    logic             clk = 1'b0;
    logic             Reset;
    logic             ce;
    logic [15:0]      Din;
    logic [DLY_W-1:0] delay_in;
    logic             delay_ld;
    logic [15:0]      Q;
    logic             q_valid;
    logic [DLY_W-1:0] delay_cur;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic [7:0] n = 8'd0;
    logic [7:0] m;

    ram_delay_line_mc #(
        .DSIZE         (DSIZE),
        .NCH           (NCH),
        .WDEPTH        (WD),
        .DEFAULT_DELAY (4)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .ce        (ce),
        .Din       (Din),
        .delay_in  (delay_in),
        .delay_ld  (delay_ld),
        .Q         (Q),
        .q_valid   (q_valid),
        .delay_cur (delay_cur)
    );

    always #5 clk = ~clk;

    // Stream model: Q is the sample taken D ce-edges earlier
    logic [15:0] hist[$];
    int          m_d = 4;
    int          m_cnt = 0;
    int          m_since = 0;
    bit          m_valid = 1'b0;
    bit          m_qok = 1'b0;
    logic [15:0] m_qexp = '0;

    always @(posedge clk) begin
        if (Reset) begin
            m_d     = 4;
            m_cnt   = 0;
            m_since = 0;
            m_valid = 1'b0;
            m_qok   = 1'b0;
        end else begin
            if (ce) begin
                hist.push_back(Din);
                m_since++;
                m_cnt++;
                if (m_since > m_d) begin
                    m_qexp = hist[hist.size() - 1 - m_d];
                    m_qok  = 1'b1;
                end else begin
                    m_qok = 1'b0;
                end
            end
            if (delay_ld) begin
                if (delay_in == 0) m_d = 1;
                else if (int'(delay_in) > WD) m_d = WD;
                else m_d = int'(delay_in);
                m_cnt = 0;
            end
            m_valid = (m_cnt >= m_d);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_valid", 32'(q_valid), 32'(m_valid));
            chk("mdl_delay", 32'(delay_cur), 32'(m_d));
            if (m_valid && m_qok) begin
                chk("mdl_q", 32'(Q), 32'(m_qexp));
            end
`ifdef RAMSR_QMASK_EN
            if (!m_valid) begin
                chk("mdl_qmask", 32'(Q), 32'h0);
            end
`endif
        end
    end

    task automatic step(input bit c, input bit l, input int dv);
        ce       = c;
        delay_ld = l;
        delay_in = DLY_W'(dv);
        Din      = {~n, n};
        @(posedge clk);
        #1;
        if (c) n++;
    endtask

    initial begin
        Reset = 1'b1;
        ce = 1'b0;
        delay_ld = 1'b0;
        delay_in = '0;
        Din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_vld", 32'(q_valid), 32'h0);
        chk("rst_dly", 32'(delay_cur), 32'd4);
        Reset = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0);
            if (i == 3) chk("fill_e3", 32'(q_valid), 32'h0);
            if (i == 4) chk("fill_e4", 32'(q_valid), 32'h1);
            if (i == 6) chk("q_e6", 32'(Q), 32'hFE01);
        end

        n = 8'd50;
        step(1, 1, 10);
        chk("ld10_vld", 32'(q_valid), 32'h0);
        for (int i = 1; i <= 15; i++) begin
            step(1, 0, 0);
            if (i == 9) chk("d10_e9", 32'(q_valid), 32'h0);
            if (i == 10) begin
                chk("d10_e10", 32'(q_valid), 32'h1);
                chk("d10_q", 32'(Q), 32'hCD32);
                chk("d10_dly", 32'(delay_cur), 32'd10);
            end
        end

        m = n;
        step(1, 1, 0);
        chk("clamp0", 32'(delay_cur), 32'd1);
        step(1, 0, 0);
        chk("d1_vld", 32'(q_valid), 32'h1);
        chk("d1_q", 32'(Q), 32'({~m, m}));
        repeat (3) step(1, 0, 0);
        step(1, 1, 15);
        chk("clamp15", 32'(delay_cur), 32'd10);
        repeat (12) step(1, 0, 0);

        step(0, 1, 3);
        chk("ld3_vld", 32'(q_valid), 32'h0);
        chk("ld3_dly", 32'(delay_cur), 32'd3);
        for (int i = 0; i < 40; i++) begin
            step((i % 2) == 0, 0, 0);
        end

        step(1, 1, 4);
        repeat (8) step(1, 0, 0);
        m = n;
        step(1, 1, 7);
`ifdef RAMSR_QMASK_EN
        chk("ldce_q", 32'(Q), 32'h0);
`else
        m = m - 8'd4;
        chk("ldce_q", 32'(Q), 32'({~m, m}));
`endif
        chk("ldce_vld", 32'(q_valid), 32'h0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            if (i == 6) chk("d7_e6", 32'(q_valid), 32'h0);
            if (i == 7) chk("d7_e7", 32'(q_valid), 32'h1);
        end

        Reset = 1'b1;
        step(1, 0, 0);
        Reset = 1'b0;
        chk("mrst_q", 32'(Q), 32'h0);
        chk("mrst_vld", 32'(q_valid), 32'h0);
        chk("mrst_dly", 32'(delay_cur), 32'd4);
        step(1, 0, 0);
`ifdef RAMSR_QMASK_EN
        chk("stale_q", 32'(Q), 32'h0);
`else
        total++;
        if (Q == 16'h0) begin
            bad++;
            $display("FAIL stale_q got=%h want=nonzero", Q);
        end
`endif
        repeat (12) step(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
